// File: rtl/tilelink_arbiter_nto1.sv
// N-to-1 TileLink-UL arbiter.
// A channel: round-robin grant among N masters. A multi-beat Put holds the
// grant for all of its beats. The master index is prepended to the source ID.
// D channel: stateless routing by the index bits of slave_d_source. The index
// is stripped before the response is delivered to the master.

// One master's D-channel delivery: qualify valid by the route hit and strip the
// index bits from the source field.
module tilelink_arbiter_nto1_d_lane #(
    parameter int TL_DW = 32,
    parameter int TL_RS = 4,
    parameter int TL_SZ = 4
) (
    input  logic             hit,
    input  logic             d_valid,
    input  logic [2:0]       d_opcode,
    input  logic [1:0]       d_param,
    input  logic [TL_SZ-1:0] d_size,
    input  logic [TL_RS-1:0] d_source,
    input  logic             d_denied,
    input  logic             d_corrupt,
    input  logic [TL_DW-1:0] d_data,
    output logic             master_d_valid,
    output logic [2:0]       master_d_opcode,
    output logic [1:0]       master_d_param,
    output logic [TL_SZ-1:0] master_d_size,
    output logic [TL_RS-1:0] master_d_source,
    output logic             master_d_denied,
    output logic             master_d_corrupt,
    output logic [TL_DW-1:0] master_d_data
);
    assign master_d_valid   = hit & d_valid;
    assign master_d_opcode  = d_opcode;
    assign master_d_param   = d_param;
    assign master_d_size    = d_size;
    assign master_d_source  = d_source;
    assign master_d_denied  = d_denied;
    assign master_d_corrupt = d_corrupt;
    assign master_d_data    = d_data;
endmodule

module tilelink_arbiter_nto1 #(
    parameter int N     = 2,
    parameter int TL_DW = 32,
    parameter int TL_AW = 32,
    parameter int TL_RS = 4,
    parameter int TL_SZ = 4,
    localparam int MW   = $clog2(N),
    localparam int SW   = TL_RS + MW,
    localparam int BW   = TL_DW / 8
) (
    input  logic                         tilelink_clock_i,
    input  logic                         tilelink_reset_i,
    // master-side A
    input  logic [N-1:0][2:0]            master_a_opcode,
    input  logic [N-1:0][2:0]            master_a_param,
    input  logic [N-1:0][TL_SZ-1:0]      master_a_size,
    input  logic [N-1:0][TL_RS-1:0]      master_a_source,
    input  logic [N-1:0][TL_AW-1:0]      master_a_address,
    input  logic [N-1:0][BW-1:0]         master_a_mask,
    input  logic [N-1:0][TL_DW-1:0]      master_a_data,
    input  logic [N-1:0]                 master_a_corrupt,
    input  logic [N-1:0]                 master_a_valid,
    output logic [N-1:0]                 master_a_ready,
    // master-side D
    output logic [N-1:0][2:0]            master_d_opcode,
    output logic [N-1:0][1:0]            master_d_param,
    output logic [N-1:0][TL_SZ-1:0]      master_d_size,
    output logic [N-1:0][TL_RS-1:0]      master_d_source,
    output logic [N-1:0]                 master_d_denied,
    output logic [N-1:0]                 master_d_corrupt,
    output logic [N-1:0]                 master_d_valid,
    output logic [N-1:0][TL_DW-1:0]      master_d_data,
    input  logic [N-1:0]                 master_d_ready,
    // slave-side A
    output logic [2:0]                   slave_a_opcode,
    output logic [2:0]                   slave_a_param,
    output logic [TL_SZ-1:0]             slave_a_size,
    output logic [SW-1:0]                slave_a_source,
    output logic [TL_AW-1:0]             slave_a_address,
    output logic [BW-1:0]                slave_a_mask,
    output logic [TL_DW-1:0]             slave_a_data,
    output logic                         slave_a_corrupt,
    output logic                         slave_a_valid,
    input  logic                         slave_a_ready,
    // slave-side D
    input  logic [2:0]                   slave_d_opcode,
    input  logic [1:0]                   slave_d_param,
    input  logic [TL_SZ-1:0]             slave_d_size,
    input  logic [SW-1:0]                slave_d_source,
    input  logic                         slave_d_denied,
    input  logic                         slave_d_corrupt,
    input  logic                         slave_d_valid,
    input  logic [TL_DW-1:0]             slave_d_data,
    output logic                         slave_d_ready
);
    localparam int LGB = $clog2(BW);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [TL_SZ-1:0] size;
        logic [SW-1:0]    source;
        logic [TL_AW-1:0] address;
        logic [BW-1:0]    mask;
        logic [TL_DW-1:0] data;
        logic             corrupt;
    } a_req_t;

    state_t        state, state_d;
    logic [MW-1:0] rr_ptr, rr_d;
    logic [MW-1:0] lock_idx, lock_d;
    logic [11:0]   beats_left, beats_d;

    logic [MW-1:0] sel;
    logic [MW-1:0] grant_idx;
    logic          a_fire;
    logic          a_multi;
    logic [11:0]   burst_rem;
    a_req_t        a_req;

    logic [MW-1:0] d_idx;
    logic          d_in_range;
    logic [N-1:0]  d_hit;

    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] x);
        if (int'(x) == N - 1) return '0;
        else                  return x + 1'b1;
    endfunction

    // Round-robin search: first valid master starting at rr_ptr, wrapping mod N.
    always_comb begin
        logic found;
        found = 1'b0;
        sel   = rr_ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && master_a_valid[(int'(rr_ptr) + k) % N]) begin
                found = 1'b1;
                sel   = MW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    // A-channel grant and ready steering; a locked burst ignores other masters.
    always_comb begin
        master_a_ready = '0;
        if (state == BURST) begin
            grant_idx                = lock_idx;
            slave_a_valid            = master_a_valid[lock_idx];
            master_a_ready[lock_idx] = slave_a_ready;
        end else begin
            grant_idx     = sel;
            slave_a_valid = |master_a_valid;
            if (|master_a_valid) master_a_ready[sel] = slave_a_ready;
        end
    end

    assign a_req.opcode  = master_a_opcode[grant_idx];
    assign a_req.param   = master_a_param[grant_idx];
    assign a_req.size    = master_a_size[grant_idx];
    assign a_req.source  = {grant_idx, master_a_source[grant_idx]};
    assign a_req.address = master_a_address[grant_idx];
    assign a_req.mask    = master_a_mask[grant_idx];
    assign a_req.data    = master_a_data[grant_idx];
    assign a_req.corrupt = master_a_corrupt[grant_idx];

    assign slave_a_opcode  = a_req.opcode;
    assign slave_a_param   = a_req.param;
    assign slave_a_size    = a_req.size;
    assign slave_a_source  = a_req.source;
    assign slave_a_address = a_req.address;
    assign slave_a_mask    = a_req.mask;
    assign slave_a_data    = a_req.data;
    assign slave_a_corrupt = a_req.corrupt;

    assign a_fire = slave_a_valid & slave_a_ready;

    // Only Puts larger than one data beat carry payload across several beats;
    // a Get is one A beat regardless of size.
    assign a_multi   = ((slave_a_opcode == 3'd0) || (slave_a_opcode == 3'd1)) &&
                       (slave_a_size > TL_SZ'(LGB));
    assign burst_rem = (12'd1 << (slave_a_size - TL_SZ'(LGB))) - 12'd1;

    // State register; reset drops any lock immediately.
    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_idx   <= '0;
            beats_left <= '0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_d;
            lock_idx   <= lock_d;
            beats_left <= beats_d;
        end
    end

    // Next-state: lock on the first beat of a burst, rotate priority on release.
    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        lock_d  = lock_idx;
        beats_d = beats_left;
        if (a_fire) begin
            case (state)
                IDLE: begin
                    if (a_multi) begin
                        state_d = BURST;
                        lock_d  = sel;
                        beats_d = burst_rem;
                    end else begin
                        rr_d = wrap_inc(sel);
                    end
                end
                BURST: begin
                    beats_d = beats_left - 12'd1;
                    if (beats_left == 12'd1) begin
                        state_d = IDLE;
                        rr_d    = wrap_inc(lock_idx);
                    end
                end
                default: ;
            endcase
        end
    end

    // D routing: an index beyond N is sunk so the slave never stalls on it.
    assign d_idx      = slave_d_source[SW-1:TL_RS];
    assign d_in_range = int'(d_idx) < N;

    always_comb begin
        d_hit = '0;
        if (d_in_range) d_hit[d_idx] = 1'b1;
    end

    assign slave_d_ready = d_in_range ? master_d_ready[d_idx] : 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_d_lane
        tilelink_arbiter_nto1_d_lane #(
            .TL_DW (TL_DW),
            .TL_RS (TL_RS),
            .TL_SZ (TL_SZ)
        ) u_d_lane (
            .hit              (d_hit[g]),
            .d_valid          (slave_d_valid),
            .d_opcode         (slave_d_opcode),
            .d_param          (slave_d_param),
            .d_size           (slave_d_size),
            .d_source         (slave_d_source[TL_RS-1:0]),
            .d_denied         (slave_d_denied),
            .d_corrupt        (slave_d_corrupt),
            .d_data           (slave_d_data),
            .master_d_valid   (master_d_valid[g]),
            .master_d_opcode  (master_d_opcode[g]),
            .master_d_param   (master_d_param[g]),
            .master_d_size    (master_d_size[g]),
            .master_d_source  (master_d_source[g]),
            .master_d_denied  (master_d_denied[g]),
            .master_d_corrupt (master_d_corrupt[g]),
            .master_d_data    (master_d_data[g])
        );
    end

    // A locked master must hold its beat until the slave accepts it.
    a_burst_stable: assert property (@(posedge tilelink_clock_i) disable iff (tilelink_reset_i)
        (state == BURST && slave_a_valid && !slave_a_ready) |=> $stable(a_req));

endmodule

// File: tb/tb_tilelink_arbiter_nto1.sv
// Directed bench for tilelink_arbiter_nto1 with N=3, 32-bit data.
module tb_tilelink_arbiter_nto1;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RS = 4;
    localparam int SZ = 4;
    localparam int SW = RS + 2;

    logic              clk, rst;
    logic [N*3-1:0]    m_a_opcode, m_a_param;
    logic [N*SZ-1:0]   m_a_size;
    logic [N*RS-1:0]   m_a_source;
    logic [N*AW-1:0]   m_a_address;
    logic [N*4-1:0]    m_a_mask;
    logic [N*DW-1:0]   m_a_data;
    logic [N-1:0]      m_a_corrupt, m_a_valid, m_a_ready;
    logic [N*3-1:0]    m_d_opcode;
    logic [N*2-1:0]    m_d_param;
    logic [N*SZ-1:0]   m_d_size;
    logic [N*RS-1:0]   m_d_source;
    logic [N-1:0]      m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
    logic [N*DW-1:0]   m_d_data;
    logic [2:0]        s_a_opcode, s_a_param;
    logic [SZ-1:0]     s_a_size;
    logic [SW-1:0]     s_a_source;
    logic [AW-1:0]     s_a_address;
    logic [3:0]        s_a_mask;
    logic [DW-1:0]     s_a_data;
    logic              s_a_corrupt, s_a_valid, s_a_ready;
    logic [2:0]        s_d_opcode;
    logic [1:0]        s_d_param;
    logic [SZ-1:0]     s_d_size;
    logic [SW-1:0]     s_d_source;
    logic              s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
    logic [DW-1:0]     s_d_data;

    int checks   = 0;
    int failures = 0;

    tilelink_arbiter_nto1 #(.N(N), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut (
        .tilelink_clock_i (clk),
        .tilelink_reset_i (rst),
        .master_a_opcode  (m_a_opcode),
        .master_a_param   (m_a_param),
        .master_a_size    (m_a_size),
        .master_a_source  (m_a_source),
        .master_a_address (m_a_address),
        .master_a_mask    (m_a_mask),
        .master_a_data    (m_a_data),
        .master_a_corrupt (m_a_corrupt),
        .master_a_valid   (m_a_valid),
        .master_a_ready   (m_a_ready),
        .master_d_opcode  (m_d_opcode),
        .master_d_param   (m_d_param),
        .master_d_size    (m_d_size),
        .master_d_source  (m_d_source),
        .master_d_denied  (m_d_denied),
        .master_d_corrupt (m_d_corrupt),
        .master_d_valid   (m_d_valid),
        .master_d_data    (m_d_data),
        .master_d_ready   (m_d_ready),
        .slave_a_opcode   (s_a_opcode),
        .slave_a_param    (s_a_param),
        .slave_a_size     (s_a_size),
        .slave_a_source   (s_a_source),
        .slave_a_address  (s_a_address),
        .slave_a_mask     (s_a_mask),
        .slave_a_data     (s_a_data),
        .slave_a_corrupt  (s_a_corrupt),
        .slave_a_valid    (s_a_valid),
        .slave_a_ready    (s_a_ready),
        .slave_d_opcode   (s_d_opcode),
        .slave_d_param    (s_d_param),
        .slave_d_size     (s_d_size),
        .slave_d_source   (s_d_source),
        .slave_d_denied   (s_d_denied),
        .slave_d_corrupt  (s_d_corrupt),
        .slave_d_valid    (s_d_valid),
        .slave_d_data     (s_d_data),
        .slave_d_ready    (s_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic [3:0] src, input logic [31:0] dat);
        m_a_valid[i]           = v;
        m_a_opcode[i*3 +: 3]   = op;
        m_a_size[i*SZ +: SZ]   = sz;
        m_a_source[i*RS +: RS] = src;
        m_a_address[i*AW +: AW] = 32'h1000_0000 + 32'(i * 'h100);
        m_a_data[i*DW +: DW]   = dat;
    endtask

    int exp_g [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst = 1'b1;
        m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0;
        m_a_address = '0; m_a_mask = '1; m_a_data = '0; m_a_corrupt = '0; m_a_valid = '0;
        m_d_ready = '0; s_a_ready = 1'b0;
        s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
        s_d_denied = 1'b0; s_d_corrupt = 1'b0; s_d_valid = 1'b0; s_d_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_slave_a_valid", 64'(s_a_valid), 64'd0);
        chk("reset_master_a_ready", 64'(m_a_ready), 64'd0);
        chk("reset_master_d_valid", 64'(m_d_valid), 64'd0);
        chk("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("reset_state", 64'(dut.state), 64'd0);
        chk("reset_beats_left", 64'(dut.beats_left), 64'd0);

        // Fairness: everyone issues single-beat Gets back to back.
        s_a_ready = 1'b1;
        for (int i = 0; i < N; i++) set_a(i, 1'b1, 3'd4, 4'd2, 4'(i + 1), 32'hA0 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_src_index", 64'(s_a_source[5:4]), 64'(exp_g[k]));
            chk("rr_src_low", 64'(s_a_source[3:0]), 64'(exp_g[k] + 1));
            chk("rr_ready", 64'(m_a_ready), 64'(3'b001 << exp_g[k]));
            @(negedge clk);
        end
        chk("rr_ptr_after6", 64'(dut.rr_ptr), 64'd0);

        // Master 0 alone, so priority moves to master 1.
        set_a(1, 1'b0, 3'd4, 4'd2, 4'd2, 32'h0);
        set_a(2, 1'b0, 3'd4, 4'd2, 4'd3, 32'h0);
        #1;
        chk("solo0_index", 64'(s_a_source[5:4]), 64'd0);
        @(negedge clk);
        chk("solo0_rr_ptr", 64'(dut.rr_ptr), 64'd1);

        // Burst lock: master 1 PutFull 16 bytes = 4 beats, master 0 keeps asking.
        set_a(1, 1'b1, 3'd0, 4'd4, 4'd3, 32'hB0);
        #1;
        chk("b1_index", 64'(s_a_source[5:4]), 64'd1);
        chk("b1_ready", 64'(m_a_ready), 64'b010);
        chk("b1_data", 64'(s_a_data), 64'hB0);
        @(negedge clk);
        chk("b1_state", 64'(dut.state), 64'd1);
        chk("b1_beats_left", 64'(dut.beats_left), 64'd3);
        chk("b1_lock_idx", 64'(dut.lock_idx), 64'd1);
        m_a_data[DW +: DW] = 32'hB1;
        #1;
        chk("b2_data", 64'(s_a_data), 64'hB1);
        chk("b2_ready", 64'(m_a_ready), 64'b010);
        @(negedge clk);
        chk("b2_beats_left", 64'(dut.beats_left), 64'd2);

        // Backpressure on the third beat for 3 cycles.
        m_a_data[DW +: DW] = 32'hB2;
        s_a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_beats_left", 64'(dut.beats_left), 64'd2);
            chk("stall_ready", 64'(m_a_ready), 64'b000);
            chk("stall_data", 64'(s_a_data), 64'hB2);
            chk("stall_index", 64'(s_a_source[5:4]), 64'd1);
            chk("stall_valid", 64'(s_a_valid), 64'd1);
            @(negedge clk);
        end
        s_a_ready = 1'b1;
        #1;
        chk("b3_ready", 64'(m_a_ready), 64'b010);
        @(negedge clk);
        chk("b3_beats_left", 64'(dut.beats_left), 64'd1);
        m_a_data[DW +: DW] = 32'hB3;
        #1;
        chk("b4_ready", 64'(m_a_ready), 64'b010);
        chk("b4_data", 64'(s_a_data), 64'hB3);
        @(negedge clk);
        chk("post_burst_state", 64'(dut.state), 64'd0);
        chk("post_burst_rr_ptr", 64'(dut.rr_ptr), 64'd2);
        set_a(1, 1'b0, 3'd0, 4'd4, 4'd3, 32'h0);
        #1;
        chk("fifth_index", 64'(s_a_source[5:4]), 64'd0);
        chk("fifth_ready", 64'(m_a_ready), 64'b001);
        @(negedge clk);
        chk("fifth_rr_ptr", 64'(dut.rr_ptr), 64'd1);

        // A large Get is still one beat.
        set_a(0, 1'b0, 3'd4, 4'd2, 4'd1, 32'h0);
        set_a(2, 1'b1, 3'd4, 4'd4, 4'd7, 32'h0);
        #1;
        chk("bigget_index", 64'(s_a_source[5:4]), 64'd2);
        @(negedge clk);
        chk("bigget_state", 64'(dut.state), 64'd0);
        chk("bigget_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        set_a(2, 1'b0, 3'd4, 4'd2, 4'd3, 32'h0);

        // D routing to master 2 with backpressure.
        s_d_valid = 1'b1; s_d_opcode = 3'd1; s_d_source = 6'h25; s_d_data = 32'hDEADBEEF;
        m_d_ready = 3'b011;
        #1;
        chk("d2_valid", 64'(m_d_valid), 64'b100);
        chk("d2_source", 64'(m_d_source[2*RS +: RS]), 64'h5);
        chk("d2_data", 64'(m_d_data[2*DW +: DW]), 64'hDEADBEEF);
        chk("d2_opcode", 64'(m_d_opcode[2*3 +: 3]), 64'd1);
        chk("d2_stall_ready", 64'(s_d_ready), 64'd0);
        m_d_ready = 3'b111;
        #1;
        chk("d2_ready", 64'(s_d_ready), 64'd1);
        @(negedge clk);
        s_d_source = 6'h0A; m_d_ready = 3'b110;
        #1;
        chk("d0_valid", 64'(m_d_valid), 64'b001);
        chk("d0_source", 64'(m_d_source[RS-1:0]), 64'hA);
        chk("d0_stall_ready", 64'(s_d_ready), 64'd0);
        m_d_ready = 3'b111;
        #1;
        chk("d0_ready", 64'(s_d_ready), 64'd1);
        @(negedge clk);
        // Index 3 does not exist with three masters: sink it.
        s_d_source = 6'h31; m_d_ready = 3'b000;
        #1;
        chk("dbad_ready", 64'(s_d_ready), 64'd1);
        chk("dbad_valid", 64'(m_d_valid), 64'd0);
        @(negedge clk);
        s_d_valid = 1'b0;

        // Reset mid-burst: PutPartial from master 1, reset after the first beat.
        set_a(1, 1'b1, 3'd1, 4'd4, 4'd9, 32'hC0);
        #1;
        chk("rb_index", 64'(s_a_source[5:4]), 64'd1);
        @(negedge clk);
        chk("rb_state", 64'(dut.state), 64'd1);
        chk("rb_beats_left", 64'(dut.beats_left), 64'd3);
        rst = 1'b1;
        set_a(0, 1'b1, 3'd4, 4'd2, 4'd1, 32'h0);
        @(negedge clk);
        chk("rb_reset_state", 64'(dut.state), 64'd0);
        chk("rb_reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("rb_reset_beats", 64'(dut.beats_left), 64'd0);
        rst = 1'b0;
        #1;
        chk("rb_grant_index", 64'(s_a_source[5:4]), 64'd0);
        chk("rb_grant_ready", 64'(m_a_ready), 64'b001);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
